// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory bank: access-size encoding,
// controller state, latched request record and size decode functions.
package data_mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Request as captured at the handshake.
  typedef struct packed {
    logic        we;
    size_e       size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Number of bytes touched by an access; 0 for the reserved encoding.
  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  // Byte-lane enable mask, lane k = byte at address + k.
  function automatic logic [NUM_LANES-1:0] size_mask(input size_e s);
    case (s)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      SZ_WORD: size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load-path formatting: keeps the low 1/2/4 bytes of the raw
// little-endian word and sign- or zero-extends them to 32 bits.
module load_extend
  import data_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic fill_b;
  logic fill_h;

  // Upper-bit fill is the sign bit for signed loads, zero otherwise.
  assign fill_b = ~is_unsigned & raw[7];
  assign fill_h = ~is_unsigned & raw[15];

  // Select and extend; word (and reserved, masked upstream) passes through.
  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = {{24{fill_b}}, raw[7:0]};
      SZ_HALF: data = {{16{fill_h}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_bank.sv
// Byte-addressed little-endian data memory with a fixed-latency
// request/response handshake (IDLE -> WAIT -> RESP). One request is
// outstanding at a time; the array is touched in the last WAIT cycle.
// Optional feature: define DATA_MEM_ALIGN_CHECK_EN to fault misaligned
// halfword/word accesses; otherwise they run as byte-sequential accesses.
module data_mem_bank
  import data_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic        rsp_valid,
  output logic [31:0] data_out,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_e       state, state_n;
  logic [3:0]   cnt, cnt_n;
  logic         req_ld;
  logic         access;
  req_t         req_q;
  logic         fault_q;

  logic [7:0]   mem [DEPTH_BYTES];

  logic [AW-1:0]                     lane_idx [NUM_LANES];
  logic [NUM_LANES-1:0][LANE_W-1:0]  raw_lanes;
  logic [NUM_LANES-1:0]              lane_en;
  logic [2:0]                        nbytes;
  logic [32:0]                       end_addr;
  logic                              range_bad;
  logic                              align_bad;
  logic                              bad;
  logic [31:0]                       ext_data;

  // Byte lanes are address-sequential, so unaligned accesses simply wrap
  // through consecutive bytes; in-range checks keep indices inside the array.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_idx[k]  = req_q.addr[AW-1:0] + AW'(k);
    assign raw_lanes[k] = mem[lane_idx[k]];
  end

  assign nbytes   = size_bytes(req_q.size);
  assign lane_en  = size_mask(req_q.size);
  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign end_addr = {1'b0, req_q.addr} + {30'b0, nbytes};
  assign range_bad = end_addr > 33'(DEPTH_BYTES);

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign align_bad = ((req_q.size == SZ_HALF) && req_q.addr[0]) ||
                     ((req_q.size == SZ_WORD) && (req_q.addr[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif

  assign bad = (req_q.size == SZ_RSVD) | range_bad | align_bad;

  load_extend u_load_extend (
    .raw         (raw_lanes),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .data        (ext_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign fault     = fault_q & rsp_valid;

  // Next-state logic: load the wait counter on accept, count down in WAIT,
  // and flag the array access on the cycle the counter reaches zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_ld  = 1'b0;
    access  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          req_ld  = 1'b1;
          cnt_n   = 4'(WAIT_STATES);
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          access  = 1'b1;
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Control state, request capture and registered response data.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      fault_q  <= 1'b0;
      data_out <= 32'd0;
      req_q    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (req_ld) begin
        req_q.we          <= req_we;
        req_q.size        <= size_e'(req_size);
        req_q.is_unsigned <= req_unsigned;
        req_q.addr        <= address;
        req_q.wdata       <= data_in;
      end
      if (access) begin
        fault_q  <= bad;
        data_out <= (bad || req_q.we) ? 32'd0 : ext_data;
      end
    end
  end

  // Array write: not reset, and suppressed whenever reset is asserted so an
  // aborted access can never commit.
  always_ff @(posedge Clk) begin
    if (Rst_n && access && req_q.we && !bad) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (lane_en[k]) mem[lane_idx[k]] <= req_q.wdata[LANE_W*k +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bank.sv
// Scoreboard bench for data_mem_bank: the driver computes each expected
// response from a byte-array model and queues it; a negedge monitor pops
// and compares whenever rsp_valid is seen, also checking latency,
// req_ready during busy cycles and data_out hold between responses.
module tb_data_mem_bank;

  localparam int DEPTH = 256;
  localparam int WS    = 3;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic        rsp_valid;
  logic [31:0] data_out;
  logic        fault;

  always #5 Clk = ~Clk;

  data_mem_bank #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .address      (address),
    .data_in      (data_in),
    .rsp_valid    (rsp_valid),
    .data_out     (data_out),
    .fault        (fault)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        flt;
    logic [31:0] data;
    int          hs;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mdl [DEPTH];
  bit          run = 0;
  bit          hold_en = 0;
  logic [31:0] last_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: byte array, little-endian, arithmetic extension.
  function automatic exp_t model(input bit we, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] a, input logic [31:0] d);
    exp_t   r;
    int     nb;
    bit     bad;
    longint v;
    r.flt = 1'b0; r.data = 32'd0; r.hs = 0;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    bad = (nb == 0) || (longint'(a) + nb > DEPTH);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    if (nb > 1 && (a % nb) != 0) bad = 1;
`endif
    if (bad) begin
      r.flt = 1'b1;
      return r;
    end
    if (we) begin
      for (int k = 0; k < nb; k++) mdl[int'(a) + k] = 8'((d >> (8 * k)) & 32'hFF);
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v += longint'(mdl[int'(a) + k]) << (8 * k);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
      r.data = 32'(v);
    end
    return r;
  endfunction

  // Monitor: response checking, busy-time ready check, hold check.
  always @(negedge Clk) begin : mon
    exp_t e;
    if (run) begin
      if (sb.size() != 0 && cyc > sb[0].hs) chk("ready_low_busy", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", data_out, e.data);
          chk("rsp_fault", 32'(fault), 32'(e.flt));
          chk("rsp_latency", 32'(cyc), 32'(e.hs + WS + 2));
          last_data = e.data;
        end
      end else if (hold_en) begin
        chk("data_hold", data_out, last_data);
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d);
    int   n;
    int   hs;
    exp_t e;
    @(negedge Clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    address = a; data_in = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge Clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    hs = cyc;
    @(posedge Clk);
    e = model(we, sz, uns, a, d);
    e.hs = hs;
    sb.push_back(e);
    #1 req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge Clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 50 cycles");
      sb.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_data_out"}, data_out, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    chk_reset_outputs("reset");
    Rst_n = 1'b1;
    last_data = 32'd0;
    run = 1; hold_en = 1;

    // Initialise every byte so later loads are well defined.
    for (int i = 0; i < DEPTH / 4; i++) issue(1, 2'd2, 0, 32'(i * 4), $urandom);

    // Directed byte/half extension vectors.
    issue(1, 2'd2, 0, 32'h10, 32'h8000_F1A5);
    issue(0, 2'd0, 0, 32'h10, 32'h0);
    chk("vec_byte_signed", last_data, 32'hFFFF_FFA5);
    issue(0, 2'd1, 1, 32'h10, 32'h0);
    chk("vec_half_unsigned", last_data, 32'h0000_F1A5);
    issue(0, 2'd1, 0, 32'h12, 32'h0);
    chk("vec_half_signed", last_data, 32'hFFFF_8000);

    // Out-of-range word store must fault and leave the top bytes alone.
    issue(1, 2'd2, 0, 32'hFE, 32'hDEAD_BEEF);
    issue(0, 2'd0, 1, 32'hFE, 32'h0);
    issue(0, 2'd0, 1, 32'hFF, 32'h0);
    issue(1, 2'd3, 0, 32'h20, 32'h1234_5678);
    issue(0, 2'd2, 0, 32'hFFFF_FFFE, 32'h0);

    // Misaligned word load (faults only with the alignment check enabled).
    issue(0, 2'd2, 0, 32'h11, 32'h0);
    issue(1, 2'd1, 0, 32'h31, 32'hA5A5_8181);
    issue(0, 2'd2, 1, 32'h30, 32'h0);

    // Reset during the first WAIT cycle aborts a store.
    @(negedge Clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    address = 32'h40; data_in = 32'h5A5A_5A5A;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    hold_en = 0;
    @(negedge Clk);
    Rst_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    last_data = 32'd0;
    chk_reset_outputs("abort");
    hold_en = 1;
    repeat (8) begin
      @(negedge Clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    issue(0, 2'd2, 0, 32'h40, 32'h0);

    // Randomised mix including boundary and reserved-size accesses.
    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      else if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(DEPTH - 6, DEPTH + 3));
      else a = 32'($urandom_range(0, DEPTH - 1));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (4) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
